// File: rtl/slot_alloc_arbiter_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : slot_alloc_arbiter_pkg                                        |
// | Brief  : FSM encoding and sizing helpers for the slot allocator        |
// | Rev    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------+
package slot_alloc_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // Round-robin pointer width, ceil(log2(n)), never below one bit.
    function automatic int ptr_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/slot_alloc_arbiter_rr_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : rr_arbiter                                                    |
// | Brief  : combinational round-robin picker starting at ptr, one-hot out |
// | Rev    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------+
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt
);

    logic w_found;
    int   w_idx;

    always_comb begin
        gnt     = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = (int'(ptr) + k) % NREQ;
            if (!w_found && req[w_idx]) begin
                gnt[w_idx] = 1'b1;
                w_found    = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/slot_alloc_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : slot_alloc_arbiter                                            |
// | Brief  : allocation/release arbiter driving an external occupancy ctr  |
// | Rev    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------+
module slot_alloc_arbiter
    import slot_alloc_arbiter_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 3,
    parameter int DEPTH = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  rel,
    input  logic             flush,
    input  logic             hold,
    output logic [NREQ-1:0]  gnt,
    output logic [NREQ-1:0]  rel_ack,
    output logic             full,
    output logic             empty,
    output logic             busy,
    output logic             err,
    output logic             cnt_ucnt,
    output logic             cnt_dcnt,
    output logic             cnt_clr,
    output logic             cnt_stall,
    input  logic [WIDTH-1:0] cnt_val,
    input  logic             cnt_co
);

    localparam int               PW      = ptr_width(NREQ);
    localparam logic [WIDTH-1:0] C_DEPTH = WIDTH'(DEPTH);

    state_t           r_state;
    state_t           w_next;
    logic [PW-1:0]    r_ptr;
    logic [PW-1:0]    w_ptr_next;
    logic [WIDTH-1:0] r_owner [NREQ];
    logic             r_err;

    logic [NREQ-1:0]  w_rel_elig;
    logic [NREQ-1:0]  w_ack_pick;
    logic [NREQ-1:0]  w_gnt_pick;
    logic             w_ack_any;
    logic             w_room;
    int               w_win;

    for (genvar i = 0; i < NREQ; i++) begin : g_elig
        assign w_rel_elig[i] = rel[i] && (r_owner[i] != '0);
    end

    // Pointer pinned at zero turns the round-robin into lowest-index-first.
    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rel_arb (
        .req (w_rel_elig),
        .ptr ('0),
        .gnt (w_ack_pick)
    );

    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_gnt_arb (
        .req (req),
        .ptr (r_ptr),
        .gnt (w_gnt_pick)
    );

    assign w_ack_any = |w_ack_pick;
    // A slot freed in the same cycle lets a grant through at the full mark.
    assign w_room    = (cnt_val < C_DEPTH) || ((cnt_val == C_DEPTH) && w_ack_any);
    assign full      = (cnt_val == C_DEPTH);
    assign empty     = (cnt_val == '0);
    assign err       = r_err;

    always_comb begin
        w_next    = r_state;
        gnt       = '0;
        rel_ack   = '0;
        cnt_ucnt  = 1'b0;
        cnt_dcnt  = 1'b0;
        cnt_clr   = 1'b0;
        cnt_stall = 1'b0;
        busy      = 1'b0;
        if (rst) begin
            w_next = ST_INIT;
        end else begin
            case (r_state)
                ST_INIT, ST_FLUSH: begin
                    cnt_clr = 1'b1;
                    busy    = 1'b1;
                    w_next  = ST_RUN;
                end
                ST_RUN: begin
                    if (hold) begin
                        cnt_stall = 1'b1;
                    end else begin
                        rel_ack  = w_ack_pick;
                        gnt      = w_room ? w_gnt_pick : '0;
                        cnt_ucnt = (|gnt) && !w_ack_any;
                        cnt_dcnt = w_ack_any && !(|gnt);
                        if (flush) begin
                            w_next = ST_FLUSH;
                        end
                    end
                end
                default: w_next = ST_INIT;
            endcase
        end
    end

    always_comb begin
        w_win = 0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                w_win = i;
            end
        end
        w_ptr_next = PW'((w_win + 1) % NREQ);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_INIT;
            r_ptr   <= '0;
            for (int i = 0; i < NREQ; i++) begin
                r_owner[i] <= '0;
            end
        end else begin
            r_state <= w_next;
            if (|gnt) begin
                r_ptr <= w_ptr_next;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (r_state == ST_FLUSH) begin
                    r_owner[i] <= '0;
                end else if (gnt[i] && !rel_ack[i]) begin
                    r_owner[i] <= r_owner[i] + 1'b1;
                end else if (rel_ack[i] && !gnt[i]) begin
                    r_owner[i] <= r_owner[i] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (cnt_co) begin
            r_err <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_slot_alloc_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : tb_slot_alloc_arbiter                                         |
// | Brief  : scoreboard bench with an occupancy counter and reference model|
// | Rev    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------+
module tb_slot_alloc_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 3;
    localparam int DEPTH = 7;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NREQ-1:0]  req = '0;
    logic [NREQ-1:0]  rel = '0;
    logic             flush = 1'b0;
    logic             hold = 1'b0;
    logic [NREQ-1:0]  gnt, rel_ack;
    logic             full, empty, busy, err;
    logic             cnt_ucnt, cnt_dcnt, cnt_clr, cnt_stall;
    logic [WIDTH-1:0] cnt_reg = '0;
    logic             co_force = 1'b0;

    always #5 clk = ~clk;

    slot_alloc_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .req(req), .rel(rel), .flush(flush), .hold(hold),
        .gnt(gnt), .rel_ack(rel_ack), .full(full), .empty(empty), .busy(busy),
        .err(err), .cnt_ucnt(cnt_ucnt), .cnt_dcnt(cnt_dcnt), .cnt_clr(cnt_clr),
        .cnt_stall(cnt_stall), .cnt_val(cnt_reg), .cnt_co(co_force)
    );

    // Attached up/down occupancy counter; carry-out is driven by the bench.
    always @(posedge clk) begin
        if (cnt_clr)
            cnt_reg <= '0;
        else if (!cnt_stall && cnt_ucnt && !cnt_dcnt)
            cnt_reg <= cnt_reg + 1'b1;
        else if (!cnt_stall && cnt_dcnt && !cnt_ucnt)
            cnt_reg <= cnt_reg - 1'b1;
    end

    typedef struct packed {
        logic [NREQ-1:0] gnt;
        logic [NREQ-1:0] ack;
        logic ucnt, dcnt, clr, stall, full, empty, busy, err, chk_err;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: phase 0 = init, 1 = run, 2 = flush.
    int m_phase = 0;
    int m_ptr   = 0;
    int m_cnt   = 0;
    int m_own [NREQ];
    bit m_err   = 1'b0;

    task automatic step(input logic r, input logic [NREQ-1:0] rq, input logic [NREQ-1:0] rl,
                        input logic fl, input logic hd, input logic co,
                        output logic [NREQ-1:0] g_o, output logic [NREQ-1:0] a_o);
        exp_t e;
        int   a, g, hits;
        @(posedge clk);
        #1;
        rst = r; req = rq; rel = rl; flush = fl; hold = hd; co_force = co;
        e = '0;
        a = -1;
        g = -1;
        e.full  = (m_cnt == DEPTH);
        e.empty = (m_cnt == 0);
        if (r) begin
            m_phase = 0;
            m_ptr   = 0;
            m_err   = 1'b0;
            for (int i = 0; i < NREQ; i++) m_own[i] = 0;
        end else begin
            e.chk_err = 1'b1;
            e.err     = m_err;
            if (m_phase != 1) begin
                e.clr  = 1'b1;
                e.busy = 1'b1;
                if (m_phase == 2)
                    for (int i = 0; i < NREQ; i++) m_own[i] = 0;
                m_cnt   = 0;
                m_phase = 1;
            end else if (hd) begin
                e.stall = 1'b1;
            end else begin
                for (int i = NREQ - 1; i >= 0; i--)
                    if (rl[i] && m_own[i] > 0) a = i;
                if (m_cnt < DEPTH || (m_cnt == DEPTH && a >= 0)) begin
                    for (int k = NREQ - 1; k >= 0; k--)
                        if (rq[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
                end
                hits = 0;
                if (a >= 0) begin e.ack[a] = 1'b1; m_own[a]--; m_cnt--; hits++; end
                if (g >= 0) begin
                    e.gnt[g] = 1'b1; m_own[g]++; m_cnt++; hits++;
                    m_ptr = (g + 1) % NREQ;
                end
                e.ucnt = (hits == 1) && (g >= 0);
                e.dcnt = (hits == 1) && (a >= 0);
                if (fl) m_phase = 2;
            end
            if (co) m_err = 1'b1;
        end
        q.push_back(e);
        g_o = e.gnt;
        a_o = e.ack;
    endtask

    // Monitor: one DUT output record per cycle, compared against the queue head.
    always @(negedge clk) begin
        exp_t e, act;
        if (q.size() > 0) begin
            e   = q.pop_front();
            act = {gnt, rel_ack, cnt_ucnt, cnt_dcnt, cnt_clr, cnt_stall,
                   full, empty, busy, err, e.chk_err};
            if (!e.chk_err) act.err = e.err;
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL outputs t=%0t gnt=%b/%b ack=%b/%b u=%b/%b d=%b/%b clr=%b/%b stall=%b/%b full=%b/%b empty=%b/%b busy=%b/%b err=%b/%b (got/expected) cnt=%0d",
                         $time, act.gnt, e.gnt, act.ack, e.ack, act.ucnt, e.ucnt, act.dcnt, e.dcnt,
                         act.clr, e.clr, act.stall, e.stall, act.full, e.full, act.empty, e.empty,
                         act.busy, e.busy, act.err, e.err, cnt_reg);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached, queue=%0d", q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NREQ-1:0] g, a, prq, prl;
        logic            fl, hd;
        for (int i = 0; i < NREQ; i++) m_own[i] = 0;
        repeat (2) step(1, '0, '0, 0, 0, 0, g, a);
        repeat (2) step(0, '0, '0, 0, 0, 0, g, a);
        repeat (4) step(0, 4'b1111, '0, 0, 0, 0, g, a);
        repeat (5) step(0, 4'b0001, '0, 0, 0, 0, g, a);
        step(0, 4'b0001, 4'b0100, 0, 0, 0, g, a);
        step(0, '0, 4'b0100, 0, 0, 0, g, a);
        repeat (3) step(0, '0, 4'b1010, 0, 0, 0, g, a);
        repeat (3) step(0, 4'b1111, '0, 1, 1, 0, g, a);
        step(0, '0, '0, 1, 0, 0, g, a);
        repeat (2) step(0, '0, '0, 0, 0, 0, g, a);
        step(0, '0, '0, 0, 0, 1, g, a);
        repeat (3) step(0, 4'b0011, '0, 0, 0, 0, g, a);
        step(1, '0, '0, 0, 0, 0, g, a);
        repeat (2) step(0, '0, '0, 0, 0, 0, g, a);

        prq = '0;
        prl = '0;
        for (int n = 0; n < 800; n++) begin
            prq = prq | NREQ'($urandom);
            prl = prl | (NREQ'($urandom) & NREQ'($urandom));
            fl  = ($urandom_range(0, 29) == 0);
            hd  = ($urandom_range(0, 7) == 0);
            step(($urandom_range(0, 299) == 0), prq, prl, fl, hd,
                 ($urandom_range(0, 399) == 0), g, a);
            prq = prq & ~g;
            prl = prl & ~a & NREQ'($urandom);
        end
        step(0, '0, '0, 0, 0, 0, g, a);
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain queue=%0d expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
